// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDigit = 2;

  // Legal parameter pair: non-zero digit that tiles the operand exactly.
  function automatic bit digit_ok(int unsigned width, int unsigned digit);
    return (digit != 0) && (width >= 2) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Start/done handshake plus operand and result bus of the serial adder.
interface addsub_serial_if #(
  parameter int unsigned WIDTH = addsub_pkg::DefWidth
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  ready, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output ready, done, sum, cout, ovf, zero
  );

endinterface

// File: rtl/fa_slice.sv
// DIGIT-bit ripple chain of full-adder cells; purely combinational.
module fa_slice #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  // Ripple the carry bit by bit; c_msb_in_o is the carry entering the top cell.
  always_comb begin
    logic c;
    c          = cin_i;
    s_o        = '0;
    c_msb_in_o = 1'b0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) c_msb_in_o = c;
      s_o[i] = x_i[i] ^ y_i[i] ^ c;
      c      = (x_i[i] & y_i[i]) | (x_i[i] & c) | (y_i[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor, DIGIT bits per clock.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DIGIT = DefDigit
) (
  input logic            clk,
  input logic            rst_n,
  addsub_serial_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = $clog2(N) + 1;

  if (!digit_ok(WIDTH, DIGIT)) begin : gen_bad_params
    $error("addsub_serial: DIGIT must be non-zero and divide WIDTH");
  end

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  acc_d;
  logic              carry_q;
  logic              last_d;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;
  logic              done_q;

  logic [DIGIT-1:0]  fa_s;
  logic              fa_cout;
  logic              fa_c_msb;

  fa_slice #(
    .DIGIT (DIGIT)
  ) u_fa_slice (
    .x_i        (a_q[DIGIT-1:0]),
    .y_i        (b_q[DIGIT-1:0]),
    .cin_i      (carry_q),
    .s_o        (fa_s),
    .cout_o     (fa_cout),
    .c_msb_in_o (fa_c_msb)
  );

  // Partial sum fills from the MSB end, so after N digits the LSB digit sits at bit 0.
  always_comb begin
    acc_d  = (acc_q >> DIGIT) | (WIDTH'(fa_s) << (WIDTH - DIGIT));
    last_d = (cnt_q == CntW'(N - 1));
  end

  // FSM, datapath shift registers and registered result/flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            // Subtract as a + ~b + 1: invert B here, the +1 enters as initial carry.
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= fa_cout;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_d) begin
            state_q <= StIdle;
            sum_q   <= acc_d;
            cout_q  <= fa_cout;
            ovf_q   <= fa_c_msb ^ fa_cout;
            zero_q  <= (acc_d == '0);
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: vector table, handshake corners, reset, DIGIT variants.
module tb_addsub_serial;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_serial_if #(.WIDTH(8)) bus ();
  addsub_serial_if #(.WIDTH(8)) bus1 ();
  addsub_serial_if #(.WIDTH(8)) bus8 ();

  addsub_serial #(.WIDTH(8), .DIGIT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  addsub_serial #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    vec_t       v;
    logic [7:0] bb;
    logic [8:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    v.a    = a;
    v.b    = b;
    v.sub  = sub;
    v.sum  = full[7:0];
    v.cout = full[8];
    v.ovf  = (a[7] == bb[7]) && (full[7] != a[7]);
    v.zero = (full[7:0] == 8'd0);
    return v;
  endfunction

  // Drive one start pulse; returns just after the accepting edge.
  task automatic launch(input vec_t v);
    exp_q.push_back(v);
    @(negedge clk);
    bus.a     = v.a;
    bus.b     = v.b;
    bus.sub   = v.sub;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc_cyc   = cyc;
    check("ready_low_after_accept", {31'd0, bus.ready}, 32'd0);
  endtask

  // Wait (bounded) for done, then score the result against the queue head.
  task automatic await_done(input string name, input int lat, output int t_done);
    bit   seen;
    vec_t v;
    seen   = 1'b0;
    t_done = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_done: got done expected none", name);
    end else begin
      t_done = cyc;
      v = exp_q.pop_front();
      check({name, "_latency"}, cyc - acc_cyc, lat);
      check({name, "_ready"}, {31'd0, bus.ready}, 32'd1);
      check({name, "_sum"}, {24'd0, bus.sum}, {24'd0, v.sum});
      check({name, "_cout"}, {31'd0, bus.cout}, {31'd0, v.cout});
      check({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, v.ovf});
      check({name, "_zero"}, {31'd0, bus.zero}, {31'd0, v.zero});
    end
  endtask

  initial begin
    int t1;
    int t2;
    int t_d1;
    int t_d8;
    int n_done;
    logic [7:0] s1;
    logic [7:0] s8;
    logic o1;
    logic o8;

    //        a      b      sub   sum    cout  ovf   zero
    tbl[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h12, 8'h34, 1'b1, 8'hDE, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};

    bus.start = 1'b0;  bus.sub = 1'b0;  bus.a = '0;  bus.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sum", {24'd0, bus.sum}, 32'd0);
    check("rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // DIGIT=1 and DIGIT=8 variants, 0x7F + 0x01
    @(negedge clk);
    bus1.a = 8'h7F; bus1.b = 8'h01; bus1.start = 1'b1;
    bus8.a = 8'h7F; bus8.b = 8'h01; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    bus8.start = 1'b0;
    acc_cyc = cyc;
    t_d1 = -1; t_d8 = -1; s1 = '0; s8 = '0; o1 = 1'b0; o8 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus1.done && t_d1 < 0) begin t_d1 = cyc; s1 = bus1.sum; o1 = bus1.ovf; end
      if (bus8.done && t_d8 < 0) begin t_d8 = cyc; s8 = bus8.sum; o8 = bus8.ovf; end
    end
    check("d1_latency", t_d1 - acc_cyc, 32'd8);
    check("d1_sum", {24'd0, s1}, 32'h80);
    check("d1_ovf", {31'd0, o1}, 32'd1);
    check("d8_latency", t_d8 - acc_cyc, 32'd1);
    check("d8_sum", {24'd0, s8}, 32'h80);
    check("d8_ovf", {31'd0, o8}, 32'd1);

    // Vector table, with one-cycle done check after each
    for (int i = 0; i < 8; i++) begin
      launch(tbl[i]);
      await_done($sformatf("vec%0d", i), 4, t1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_width", i), {31'd0, bus.done}, 32'd0);
    end

    // start mid-RUN with different operands is ignored
    launch(model(8'h20, 8'h10, 1'b0));
    @(posedge clk);
    #1;
    bus.a = 8'h11; bus.b = 8'h11; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    await_done("midrun", 4, t1);
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("midrun_no_extra_done", n_done, 32'd0);

    // Back-to-back: start held through the done cycle
    launch(model(8'h05, 8'h03, 1'b0));
    await_done("b2b_first", 4, t1);
    exp_q.push_back(model(8'h80, 8'h01, 1'b1));
    bus.a = 8'h80; bus.b = 8'h01; bus.sub = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc_cyc = cyc;
    check("b2b_done_width", {31'd0, bus.done}, 32'd0);
    await_done("b2b_second", 4, t2);
    check("b2b_interval", t2 - t1, 32'd5);

    // Reset during RUN cycle 2
    launch(model(8'h7F, 8'h01, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_sum", {24'd0, bus.sum}, 32'd0);
    check("midrst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("midrst_no_done", n_done, 32'd0);
    launch(model(8'hC0, 8'h40, 1'b1));
    await_done("post_rst", 4, t1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
